// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl
//   Bit-serial adder controller: one shared full-adder cell is stepped over a
//   WIDTH-bit operand pair, LSB first, one bit per clock.
//
//   Parameters:
//     WIDTH      operand / sum width (2..32)
//   Ports:
//     clk, rst_n            clock, asynchronous active-low reset
//     in_valid/in_ready     operand handshake (a, b, cin sampled on accept)
//     out_valid/out_ready   result handshake (sum, cout held while out_valid)
//     busy                  operation in progress (RUN or DONE)
//     ovf                   signed overflow, only when SERIAL_ADDER_OVF_EN
//
//   Optional feature macro: SERIAL_ADDER_OVF_EN adds the ovf port/register.

// One-bit full-adder cell shared across all bit positions.
module serial_fa (
  input  logic x,
  input  logic y,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = x ^ y ^ ci;
  assign co = (x & y) | (ci & (x ^ y));
endmodule

module serial_adder_ctrl #(
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t         state, state_nx;
  logic [WIDTH-1:0] a_sh, b_sh;
  logic           c;
  logic [CW-1:0]  cnt;
  logic           fa_s, fa_co;

  serial_fa u_fa (
    .x  (a_sh[0]),
    .y  (b_sh[0]),
    .ci (c),
    .s  (fa_s),
    .co (fa_co)
  );

  // Handshake/status outputs decode straight from the state register.
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (in_valid)        state_nx = RUN;
      RUN:     if (cnt == LAST)     state_nx = DONE;
      DONE:    if (out_ready)       state_nx = IDLE;
      default:                      state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh <= '0;
      b_sh <= '0;
      c    <= 1'b0;
      cnt  <= '0;
      sum  <= '0;
      cout <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      ovf  <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          a_sh <= a;
          b_sh <= b;
          c    <= cin;
          cnt  <= '0;
          sum  <= '0;
`ifdef SERIAL_ADDER_OVF_EN
          ovf  <= 1'b0;
`endif
        end
        RUN: begin
          sum[cnt] <= fa_s;
          c        <= fa_co;
          a_sh     <= a_sh >> 1;
          b_sh     <= b_sh >> 1;
          cnt      <= cnt + 1'b1;
          if (cnt == LAST) begin
            cout <= fa_co;
`ifdef SERIAL_ADDER_OVF_EN
            // c is the carry into the MSB on this last step.
            ovf  <= c ^ fa_co;
`endif
          end
        end
        default: ;
      endcase
    end
  end

endmodule
